// File: rtl/jtag_pkg.sv
// ============================================================================
// Module : jtag_pkg
// Brief  : TAP state encoding and instruction opcode constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtag_pkg;

    typedef enum logic [3:0] {
        ST_EXIT2_DR   = 4'h0,
        ST_EXIT1_DR   = 4'h1,
        ST_SHIFT_DR   = 4'h2,
        ST_PAUSE_DR   = 4'h3,
        ST_SELECT_IR  = 4'h4,
        ST_UPDATE_DR  = 4'h5,
        ST_CAPTURE_DR = 4'h6,
        ST_SELECT_DR  = 4'h7,
        ST_EXIT2_IR   = 4'h8,
        ST_EXIT1_IR   = 4'h9,
        ST_SHIFT_IR   = 4'hA,
        ST_PAUSE_IR   = 4'hB,
        ST_RUN_IDLE   = 4'hC,
        ST_UPDATE_IR  = 4'hD,
        ST_CAPTURE_IR = 4'hE,
        ST_TLR        = 4'hF
    } tap_state_t;

    localparam int unsigned c_opc_idcode    = 1;
    localparam int unsigned c_opc_user_base = 2;
    // All-ones, truncated to the instruction register width at the point of use
    localparam logic [31:0] c_opc_bypass    = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
// ============================================================================
// Module : jtag_tap_fsm
// Brief  : IEEE 1149.1 TAP controller state register, transitions and decodes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_trst_n,
    input  logic       i_tms,
    output tap_state_t o_state,
    output logic       o_tlr,
    output logic       o_capture_ir,
    output logic       o_shift_ir,
    output logic       o_update_ir,
    output logic       o_capture_dr,
    output logic       o_shift_dr,
    output logic       o_update_dr
);

    tap_state_t r_state;
    tap_state_t w_next;

    always_ff @(posedge i_tck) begin
        if (!i_trst_n) r_state <= ST_TLR;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_TLR:        w_next = i_tms ? ST_TLR       : ST_RUN_IDLE;
            ST_RUN_IDLE:   w_next = i_tms ? ST_SELECT_DR : ST_RUN_IDLE;
            ST_SELECT_DR:  w_next = i_tms ? ST_SELECT_IR : ST_CAPTURE_DR;
            ST_CAPTURE_DR: w_next = i_tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_SHIFT_DR:   w_next = i_tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_EXIT1_DR:   w_next = i_tms ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:   w_next = i_tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
            ST_EXIT2_DR:   w_next = i_tms ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR:  w_next = i_tms ? ST_SELECT_DR : ST_RUN_IDLE;
            ST_SELECT_IR:  w_next = i_tms ? ST_TLR       : ST_CAPTURE_IR;
            ST_CAPTURE_IR: w_next = i_tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_SHIFT_IR:   w_next = i_tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_EXIT1_IR:   w_next = i_tms ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:   w_next = i_tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
            ST_EXIT2_IR:   w_next = i_tms ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR:  w_next = i_tms ? ST_SELECT_DR : ST_RUN_IDLE;
            default:       w_next = ST_TLR;
        endcase
    end

    always_comb begin
        o_state      = r_state;
        o_tlr        = (r_state == ST_TLR);
        o_capture_ir = (r_state == ST_CAPTURE_IR);
        o_shift_ir   = (r_state == ST_SHIFT_IR);
        o_update_ir  = (r_state == ST_UPDATE_IR);
        o_capture_dr = (r_state == ST_CAPTURE_DR);
        o_shift_dr   = (r_state == ST_SHIFT_DR);
        o_update_dr  = (r_state == ST_UPDATE_DR);
    end

endmodule

`default_nettype wire

// File: rtl/jtag_tap_multi.sv
// ============================================================================
// Module : jtag_tap_multi
// Brief  : JTAG TAP with IR, BYPASS, IDCODE and NUM_DR user data registers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tap_multi
    import jtag_pkg::*;
#(
    parameter int unsigned           IR_WIDTH   = 4,
    parameter int unsigned           DR_WIDTH   = 32,
    parameter int unsigned           NUM_DR     = 3,
    parameter logic [DR_WIDTH-1:0]   IDCODE_VAL = 32'h1234_5001
) (
    input  logic                         TCK,
    input  logic                         TRST_N,
    input  logic                         TMS,
    input  logic                         TDI,
    output logic                         TDO,
    output logic                         TDO_EN,
    input  logic [NUM_DR*DR_WIDTH-1:0]   dr_capture_val,
    output logic [DR_WIDTH-1:0]          dr_update_val,
    output logic [NUM_DR-1:0]            dr_update,
    output logic [NUM_DR-1:0]            dr_sel,
    output logic [3:0]                   tap_state
);

    localparam logic [IR_WIDTH-1:0] c_ir_idcode = IR_WIDTH'(c_opc_idcode);
    localparam logic [IR_WIDTH-1:0] c_ir_bypass = c_opc_bypass[IR_WIDTH-1:0];

    tap_state_t w_state;
    logic w_tlr, w_cap_ir, w_sh_ir, w_upd_ir, w_cap_dr, w_sh_dr, w_upd_dr;

    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] r_ir_sh;
    logic [DR_WIDTH-1:0] r_dr_sh;
    logic                r_bypass;
    logic [NUM_DR-1:0]   r_dr_sel;
    logic [NUM_DR-1:0]   r_upd;
    logic [DR_WIDTH-1:0] r_upd_val;

    logic [NUM_DR-1:0]   w_sel_next;
    logic [DR_WIDTH-1:0] w_user_cap;
    logic                w_idcode;
    logic                w_bypass;

    jtag_tap_fsm u_fsm (
        .i_tck        (TCK),
        .i_trst_n     (TRST_N),
        .i_tms        (TMS),
        .o_state      (w_state),
        .o_tlr        (w_tlr),
        .o_capture_ir (w_cap_ir),
        .o_shift_ir   (w_sh_ir),
        .o_update_ir  (w_upd_ir),
        .o_capture_dr (w_cap_dr),
        .o_shift_dr   (w_sh_dr),
        .o_update_dr  (w_upd_dr)
    );

    // User DR k answers to opcode k+2; the one-hot select is decoded ahead of Update-IR
    always_comb begin
        w_sel_next = '0;
        w_user_cap = '0;
        for (int k = 0; k < int'(NUM_DR); k++) begin
            if (r_ir_sh == IR_WIDTH'(k + int'(c_opc_user_base))) w_sel_next[k] = 1'b1;
            if (r_dr_sel[k]) w_user_cap = w_user_cap | dr_capture_val[k*DR_WIDTH +: DR_WIDTH];
        end
        w_idcode = (r_ir == c_ir_idcode);
        w_bypass = (r_ir == c_ir_bypass) || (!w_idcode && (r_dr_sel == '0));
    end

    always_ff @(posedge TCK) begin
        if (!TRST_N || w_tlr) begin
            r_ir     <= c_ir_idcode;
            r_dr_sel <= '0;
        end else if (w_upd_ir) begin
            r_ir     <= r_ir_sh;
            r_dr_sel <= w_sel_next;
        end
    end

    always_ff @(posedge TCK) begin
        if (!TRST_N)       r_ir_sh <= '0;
        else if (w_cap_ir) r_ir_sh <= IR_WIDTH'(2'b01);
        else if (w_sh_ir)  r_ir_sh <= {TDI, r_ir_sh[IR_WIDTH-1:1]};
    end

    // IDCODE and the user registers share one shift chain; BYPASS has its own bit
    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            r_dr_sh  <= '0;
            r_bypass <= 1'b0;
        end else if (w_cap_dr) begin
            if (w_bypass)      r_bypass <= 1'b0;
            else if (w_idcode) r_dr_sh  <= IDCODE_VAL;
            else               r_dr_sh  <= w_user_cap;
        end else if (w_sh_dr) begin
            if (w_bypass) r_bypass <= TDI;
            else          r_dr_sh  <= {TDI, r_dr_sh[DR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge TCK) begin
        r_upd <= '0;
        if (!TRST_N) begin
            r_upd_val <= '0;
        end else if (w_upd_dr && !w_bypass && !w_idcode) begin
            r_upd     <= r_dr_sel;
            r_upd_val <= r_dr_sh;
        end
    end

    always_comb begin
        TDO_EN = w_sh_ir | w_sh_dr;
        TDO    = 1'b0;
        if (w_sh_ir)      TDO = r_ir_sh[0];
        else if (w_sh_dr) TDO = w_bypass ? r_bypass : r_dr_sh[0];
    end

    assign dr_update_val = r_upd_val;
    assign dr_update     = r_upd;
    assign dr_sel        = r_dr_sel;
    assign tap_state     = w_state;

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_multi.sv
// ============================================================================
// Module : tb_jtag_tap_multi
// Brief  : Directed self-checking bench for jtag_tap_multi (default parameters).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_tap_multi;

    logic        TCK = 1'b0;
    logic        TRST_N, TMS, TDI;
    logic        TDO, TDO_EN;
    logic [95:0] dr_capture_val;
    logic [31:0] dr_update_val;
    logic [2:0]  dr_update, dr_sel;
    logic [3:0]  tap_state;

    int   total = 0;
    int   bad   = 0;
    logic last_tdo;

    logic [31:0] dout;
    logic [3:0]  iout;
    logic        path_tms [16];
    logic [3:0]  path_st  [16];

    jtag_tap_multi dut (
        .TCK            (TCK),
        .TRST_N         (TRST_N),
        .TMS            (TMS),
        .TDI            (TDI),
        .TDO            (TDO),
        .TDO_EN         (TDO_EN),
        .dr_capture_val (dr_capture_val),
        .dr_update_val  (dr_update_val),
        .dr_update      (dr_update),
        .dr_sel         (dr_sel),
        .tap_state      (tap_state)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // TDO is sampled before the edge that shifts it out
    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        last_tdo = TDO;
        @(posedge TCK);
        #1;
    endtask

    task automatic do_reset();
        TRST_N = 1'b0;
        step(1'b0, 1'b0);
        TRST_N = 1'b1;
    endtask

    // Run-Test/Idle -> Shift-DR, shift n bits, Update-DR, back to Run-Test/Idle
    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] o);
        o = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i]);
            o[i] = last_tdo;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [3:0] v, output logic [3:0] o);
        o = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, v[i]);
            o[i] = last_tdo;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        dr_capture_val = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_0000};
        TMS = 1'b1;
        TDI = 1'b0;

        // Reset values
        do_reset();
        check("rst_state", tap_state, 4'hF);
        check("rst_tdo_en", TDO_EN, 1'b0);
        check("rst_tdo", TDO, 1'b0);
        check("rst_sel", dr_sel, 3'b000);
        check("rst_upd", dr_update, 3'b000);
        check("rst_upd_val", dr_update_val, 32'h0);
        step(1'b0, 1'b0);
        check("idle_state", tap_state, 4'hC);
        check("idle_tdo_en", TDO_EN, 1'b0);

        // IDCODE selected after reset
        shift_dr(32, 32'h0, dout);
        check("idcode_out", dout, 32'h1234_5001);
        check("idcode_no_upd", dr_update, 3'b000);

        // BYPASS: one-bit delay with leading captured zero
        load_ir(4'hF, iout);
        check("ir_capture", iout, 4'b0001);
        check("bypass_sel", dr_sel, 3'b000);
        shift_dr(8, 32'hA5, dout);
        check("bypass_out", dout, 32'h4A);
        check("bypass_no_upd", dr_update, 3'b000);
        check("bypass_upd_val", dr_update_val, 32'h0);

        // User DR 0
        load_ir(4'h2, iout);
        check("ir_capture2", iout, 4'b0001);
        check("user0_sel", dr_sel, 3'b001);
        shift_dr(32, 32'hDEAD_BEEF, dout);
        check("user0_capture", dout, 32'hCAFE_0000);
        check("user0_pulse", dr_update, 3'b001);
        check("user0_val", dr_update_val, 32'hDEAD_BEEF);
        step(1'b0, 1'b0);
        check("user0_pulse_end", dr_update, 3'b000);

        // User DR 2
        load_ir(4'h4, iout);
        check("user2_sel", dr_sel, 3'b100);
        shift_dr(32, 32'h0F0F_0F0F, dout);
        check("user2_capture", dout, 32'h3333_3333);
        check("user2_pulse", dr_update, 3'b100);
        check("user2_val", dr_update_val, 32'h0F0F_0F0F);

        // Unassigned opcode behaves as BYPASS
        load_ir(4'h7, iout);
        check("op7_sel", dr_sel, 3'b000);
        shift_dr(4, 32'hB, dout);
        check("op7_out", dout, 32'h6);
        check("op7_no_upd", dr_update, 3'b000);
        check("op7_upd_val", dr_update_val, 32'h0F0F_0F0F);

        // Reset in the middle of Shift-DR
        load_ir(4'h2, iout);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        check("mid_in_shift", tap_state, 4'h2);
        TRST_N = 1'b0;
        step(1'b0, 1'b1);
        TRST_N = 1'b1;
        check("mid_rst_state", tap_state, 4'hF);
        check("mid_rst_upd", dr_update, 3'b000);
        check("mid_rst_sel", dr_sel, 3'b000);
        check("mid_rst_val", dr_update_val, 32'h0);
        step(1'b0, 1'b0);
        check("mid_rst_upd2", dr_update, 3'b000);
        shift_dr(32, 32'h0, dout);
        check("mid_rst_idcode", dout, 32'h1234_5001);

        // Walk every state, then five TMS=1 must land in Test-Logic-Reset
        path_tms = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        path_st  = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5,
                     4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
        for (int p = 0; p < 16; p++) begin
            do_reset();
            for (int j = 0; j <= p; j++) step(path_tms[j], 1'b0);
            check($sformatf("walk_state_%0d", p), tap_state, path_st[p]);
            for (int j = 0; j < 5; j++) step(1'b1, 1'b0);
            check($sformatf("walk_tlr_%0d", p), tap_state, 4'hF);
        end

        // Pause-DR holds the shift register
        do_reset();
        step(1'b0, 1'b0);
        load_ir(4'h3, iout);
        check("user1_sel", dr_sel, 3'b010);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        dout = '0;
        for (int i = 0; i < 9; i++) begin
            step(i == 8, 1'b0);
            dout[i] = last_tdo;
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        check("pause_state", tap_state, 4'h3);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("resume_state", tap_state, 4'h2);
        for (int i = 9; i < 32; i++) begin
            step(i == 31, 1'b0);
            dout[i] = last_tdo;
        end
        check("pause_capture", dout, 32'h2222_2222);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("pause_pulse", dr_update, 3'b010);
        check("pause_val", dr_update_val, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
